// File: rtl/mac_pe_vec_if.sv
// Handshake bundle for mac_pe_vec: operand beat stream in, one result per vector out.
// Parameters must match those of the attached mac_pe_vec instance.
interface mac_pe_vec_if #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 32,
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*IN_W-1:0]   in_a;
    logic [LANES*IN_W-1:0]   in_b;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        out_data;
    logic                    out_sat;
    logic [CNT_W-1:0]        out_count;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_count
    );
endinterface

// File: rtl/mac_pe_vec.sv
// Vector MAC PE: LANES signed products per beat, adder-tree reduce, accumulate until in_last.
// Latency: two register stages (product register, then result register) from beat capture to out_valid.
// Backpressure: only a pending last beat stalls, and only while an unconsumed result sits in the output register.
module mac_pe_vec #(
    parameter int IN_W     = 8,
    parameter int ACC_W    = 32,
    parameter int LANES    = 4,
    parameter int CNT_W    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    mac_pe_vec_if.slave  bus
);
    localparam int PW = 2 * IN_W;

    logic signed [IN_W-1:0]  w_a_lane [LANES];
    logic signed [IN_W-1:0]  w_b_lane [LANES];
    logic signed [PW-1:0]    w_prod   [LANES];
    logic signed [PW-1:0]    r_prod   [LANES];
    logic                    r_s1_vld;
    logic                    r_s1_last;

    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sticky;

    logic                    r_out_vld;
    logic [ACC_W-1:0]        r_out_dat;
    logic                    r_out_sat;
    logic [CNT_W-1:0]        r_out_cnt;

    logic                    w_stall;
    logic                    w_accept;
    logic                    w_s2_go;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W:0]   w_raw;
    logic                    w_ovf;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;

    // A last beat in S1 cannot retire while the output register is still occupied.
    assign w_stall  = r_out_vld & ~bus.out_ready & r_s1_vld & r_s1_last;
    assign w_accept = bus.in_valid & ~w_stall;
    assign w_s2_go  = r_s1_vld & ~w_stall;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_a_lane[i] = bus.in_a[i*IN_W +: IN_W];
            w_b_lane[i] = bus.in_b[i*IN_W +: IN_W];
            w_prod[i]   = PW'(w_a_lane[i]) * PW'(w_b_lane[i]);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + ACC_W'(r_prod[i]);
        end
    end

    // One extra bit exposes signed overflow of the accumulate.
    always_comb begin
        w_raw     = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_sum);
        w_ovf     = w_raw[ACC_W] ^ w_raw[ACC_W-1];
        w_acc_nxt = w_raw[ACC_W-1:0];
        if (SATURATE && w_ovf) begin
            w_acc_nxt = w_raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end
        w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            for (int i = 0; i < LANES; i++) r_prod[i] <= '0;
        end else if (!w_stall) begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_last <= bus.in_last;
                for (int i = 0; i < LANES; i++) r_prod[i] <= w_prod[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (w_s2_go) begin
            if (r_s1_last) begin
                r_acc    <= '0;
                r_cnt    <= '0;
                r_sticky <= 1'b0;
            end else begin
                r_acc    <= w_acc_nxt;
                r_cnt    <= w_cnt_nxt;
                r_sticky <= r_sticky | w_ovf;
            end
        end
    end

    // Load wins over consume, so a result can retire and be replaced in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_out_sat <= 1'b0;
            r_out_cnt <= '0;
        end else if (w_s2_go && r_s1_last) begin
            r_out_vld <= 1'b1;
            r_out_dat <= w_acc_nxt;
            r_out_sat <= r_sticky | w_ovf;
            r_out_cnt <= w_cnt_nxt;
        end else if (r_out_vld && bus.out_ready) begin
            r_out_vld <= 1'b0;
        end
    end

    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = r_out_vld;
    assign bus.out_data  = r_out_dat;
    assign bus.out_sat   = r_out_sat;
    assign bus.out_count = r_out_cnt;
endmodule
